operand_fetch: RTL
==================

// Module: operand_fetch
// PURPOSE
//  Decode/operand-fetch stage directly upstream of execute. Accepts 16-bit ALU instructions,
//  reads the 16-entry register file and tracks in-flight destinations in a scoreboard.
//  Forwards the immediately-preceding result (operand2 via depi/dep, operand1 via internal mux),
//  stalls on older unresolved hazards, and holds the architectural NZCV register fed to execute.
// PARAMETERS
//  DATA_W   32  operand/result width
//  NREG     16  register file depth (address width 4)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       instr valid
//  in_ready   out  1       stage accepts instr this cycle (combinational)
//  instr      in   16      [15:12] op_code, [11:8] rd, [7:4] rs1, [3:0] rs2
//  wb_en      in   1       writeback strobe
//  wb_addr    in   4       writeback register
//  wb_data    in   DATA_W  writeback value
//  fwd_data   in   DATA_W  execute result of previously issued instr (stable before posedge)
//  nzcv_in    in   4       execute flags output
//  out_valid  out  1       registered: op_code/opr1/opr2/dep/depi/dst are a real instr
//  op_code    out  4       registered opcode to execute
//  opr1       out  DATA_W  registered operand 1
//  opr2       out  DATA_W  registered operand 2 (register file value)
//  depi       out  1       registered: execute must use dep instead of opr2
//  dep        out  DATA_W  registered forwarded operand 2
//  dst        out  4       registered destination for writeback
//  out_we     out  1       registered: instr writes rd (op_code[3]==0) and out_valid
//  nzcv_old   out  4       architectural flags register
// BEHAVIOUR
//  - Reset: all outputs 0, scoreboard pending[15:0]=0, state=RUN, register file not cleared.
//  - Writes: op_code[3]==0 writes rd; op_code[3]==1 does not (mirrors execute is_write).
//  - RF read bypass: wb_en && wb_addr==rsX in same cycle -> read returns wb_data.
//  - Prev = instr issued on the last edge (out_valid && out_we, destination dst).
//  - Forward: rs2==dst of Prev -> depi=1, dep<=fwd_data; rs1==dst of Prev -> opr1<=fwd_data.
//    Forwarding takes priority over RF/wb bypass.
//  - Hazard: rsX pending in scoreboard and not forwardable from Prev (after wb_en clear this
//    cycle is applied) -> stall.
//  - FSM RUN: in_valid && !hazard -> issue (out_valid=1, in_ready=1, 1-cycle latency).
//    in_valid && hazard -> in_ready=0, bubble issued, go STALL.
//  - FSM STALL: instr held by upstream (in_valid must stay 1, instr stable).
//    Bubble each cycle until hazard clears, then issue and return RUN.
//  - Bubble/no input: out_valid=0, out_we=0, depi=0, op_code/opr1/opr2/dep/dst hold last value.
//    Consumers gate flag/result use with out_valid.
//  - Scoreboard: set pending[rd] on issue of a writing instr, clear pending[wb_addr] on wb_en.
//    Simultaneous set and clear of the same address -> set wins (remains 1).
//  - Prev's scoreboard bit stays set until its wb_en; forwarding suppresses the stall only for Prev.
//  - Flags: nzcv_old <= nzcv_in on the edge after a cycle with out_valid=1, else holds.
//  - rs1==rs2==Prev dst: both paths forward, depi=1.
//  - Reset mid-stall: state->RUN, scoreboard cleared, in-flight instrs discarded, out_valid=0.
// TESTING
//  1 reset; wb r1=5,r2=3; instr ADD(0100) rd=3 rs1=1 rs2=2 -> next edge out_valid=1,
//    opr1=5, opr2=3, depi=0, out_we=1, dst=3.
//  2 back-to-back: ADD rd=4 then AND(0000) rs1=5 rs2=4, fwd_data=0x1234 ->
//    2nd issue depi=1, dep=0x1234, no stall.
//  3 older hazard: issue rd=6, one unrelated instr, then rs1=6 -> in_ready=0 and bubbles
//    until wb_en addr 6 data 0x77; same cycle issue opr1=0x77.
//  4 wb bypass: wb_en addr 2 data 0xAA in same cycle as read rs2=2 (not pending) -> opr2=0xAA.
//  5 set/clear collision: issue rd=7 while wb_en addr 7 -> pending[7] stays 1,
//    later rs1=7 read stalls until next wb.
//  6 rst asserted during STALL -> next edge out_valid=0, in_ready=1, nzcv_old=0,
//    scoreboard empty (rs1=6 issues immediately).

Source files
------------

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - decode/operand-fetch stage with scoreboard, forwarding and flags register
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  input  logic              wb_en,
  input  logic [3:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] fwd_data,
  input  logic [3:0]        nzcv_in,
  output logic              out_valid,
  output logic [3:0]        op_code,
  output logic [DATA_W-1:0] opr1,
  output logic [DATA_W-1:0] opr2,
  output logic              depi,
  output logic [DATA_W-1:0] dep,
  output logic [3:0]        dst,
  output logic              out_we,
  output logic [3:0]        nzcv_old
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t              state_q;
  state_t              state_d;

  logic [DATA_W-1:0]   rf [NREG];
  logic [NREG-1:0]     pending;
  logic [NREG-1:0]     wb_clr_mask;
  logic [NREG-1:0]     set_mask;
  logic [NREG-1:0]     pend_eff;

  logic [3:0]          op_in;
  logic [3:0]          rd;
  logic [3:0]          rs1;
  logic [3:0]          rs2;
  logic                writes_rd;

  logic                fwd1;
  logic                fwd2;
  logic                hazard;
  logic                issue;
  logic [DATA_W-1:0]   rd1_val;
  logic [DATA_W-1:0]   rd2_val;

  assign op_in     = instr[15:12];
  assign rd        = instr[11:8];
  assign rs1       = instr[7:4];
  assign rs2       = instr[3:0];
  assign writes_rd = ~op_in[3];

  // Register file write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wb_en) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // Read ports with same-cycle writeback bypass
  always_comb begin
    rd1_val = (wb_en && (wb_addr == rs1)) ? wb_data : rf[rs1];
    rd2_val = (wb_en && (wb_addr == rs2)) ? wb_data : rf[rs2];
  end

  // Scoreboard masks: this cycle's writeback clears, an issued writer sets
  always_comb begin
    wb_clr_mask = '0;
    set_mask    = '0;
    if (wb_en) begin
      wb_clr_mask[wb_addr] = 1'b1;
    end
    if (issue && writes_rd) begin
      set_mask[rd] = 1'b1;
    end
    pend_eff = pending & ~wb_clr_mask;
  end

  // Hazard detect: a pending source stalls unless the previous issue can forward it
  always_comb begin
    fwd1   = out_we && (dst == rs1);
    fwd2   = out_we && (dst == rs2);
    hazard = (pend_eff[rs1] && !fwd1) || (pend_eff[rs2] && !fwd2);
  end

  // Scoreboard update; set wins over a simultaneous clear of the same register
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pend_eff | set_mask;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: enter STALL on a blocked instr, leave once it can issue
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (in_valid && hazard) state_d = STALL;
      STALL:   if (!in_valid || !hazard) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM outputs: issue whenever the presented instr has no unresolved hazard
  always_comb begin
    issue    = 1'b0;
    in_ready = 1'b1;
    case (state_q)
      RUN, STALL: begin
        issue    = in_valid && !hazard;
        in_ready = !(in_valid && hazard);
      end
      default: begin
        issue    = 1'b0;
        in_ready = 1'b1;
      end
    endcase
  end

  // Issue register toward execute; payload holds during bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_we    <= 1'b0;
      depi      <= 1'b0;
      op_code   <= '0;
      opr1      <= '0;
      opr2      <= '0;
      dep       <= '0;
      dst       <= '0;
    end else begin
      out_valid <= issue;
      out_we    <= issue && writes_rd;
      depi      <= issue && fwd2;
      if (issue) begin
        op_code <= op_in;
        dst     <= rd;
        opr1    <= fwd1 ? fwd_data : rd1_val;
        opr2    <= rd2_val;
        if (fwd2) begin
          dep <= fwd_data;
        end
      end
    end
  end

  // Architectural flags: capture execute flags after each real instr
  always_ff @(posedge clk) begin
    if (rst) begin
      nzcv_old <= '0;
    end else if (out_valid) begin
      nzcv_old <= nzcv_in;
    end
  end

endmodule
